// File: rtl/rv32_pkg.sv
// RV32I decode definitions shared by the decoder and the decode stage.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [3:0] {
    OC_NONE   = 4'd0,
    OC_LOAD   = 4'd1,
    OC_STORE  = 4'd2,
    OC_BRANCH = 4'd3,
    OC_JAL    = 4'd4,
    OC_JALR   = 4'd5,
    OC_LUI    = 4'd6,
    OC_AUIPC  = 4'd7,
    OC_OP     = 4'd8,
    OC_OPIMM  = 4'd9
  } opclass_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_Z = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_sel_e;

  // Build the sign-extended immediate for the selected instruction format.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] instr, input imm_sel_e sel);
    logic [XLEN-1:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {XLEN{1'b0}};
    endcase
    return imm;
  endfunction

  // Map funct3 (plus the funct7[5] alternate bit) onto an ALU operation.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I instruction decoder.
module rv32_decoder
  import rv32_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output alu_op_e         alu_op,
  output opclass_e        opclass,
  output logic            use_imm,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            writes_rd,
  output logic            illegal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  imm_sel_e   imm_sel_s;
  logic       bad_s;
  logic       rs1_s;
  logic       rs2_s;
  logic       wr_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign imm      = imm_gen(instr, imm_sel_s);

  // Classify the opcode and derive operand usage, ALU op and legality.
  always_comb begin
    opclass   = OC_NONE;
    alu_op    = ALU_ADD;
    imm_sel_s = IMM_Z;
    use_imm   = 1'b0;
    rs1_s     = 1'b0;
    rs2_s     = 1'b0;
    wr_s      = 1'b0;
    bad_s     = 1'b0;
    case (opcode_s)
      OPC_LOAD: begin
        opclass   = OC_LOAD;
        imm_sel_s = IMM_I;
        use_imm   = 1'b1;
        rs1_s     = 1'b1;
        wr_s      = 1'b1;
        bad_s     = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
      end
      OPC_STORE: begin
        opclass   = OC_STORE;
        imm_sel_s = IMM_S;
        use_imm   = 1'b1;
        rs1_s     = 1'b1;
        rs2_s     = 1'b1;
        bad_s     = (funct3_s[2] == 1'b1) || (funct3_s == 3'b011);
      end
      OPC_BRANCH: begin
        opclass   = OC_BRANCH;
        imm_sel_s = IMM_B;
        rs1_s     = 1'b1;
        rs2_s     = 1'b1;
        // Comparison flavour: equality via SUB, signed/unsigned via SLT/SLTU
        if (funct3_s[2:1] == 2'b00) begin
          alu_op = ALU_SUB;
        end else if (funct3_s[2:1] == 2'b10) begin
          alu_op = ALU_SLT;
        end else begin
          alu_op = ALU_SLTU;
        end
        bad_s     = (funct3_s[2:1] == 2'b01);
      end
      OPC_JAL: begin
        opclass   = OC_JAL;
        imm_sel_s = IMM_J;
        use_imm   = 1'b1;
        wr_s      = 1'b1;
      end
      OPC_JALR: begin
        opclass   = OC_JALR;
        imm_sel_s = IMM_I;
        use_imm   = 1'b1;
        rs1_s     = 1'b1;
        wr_s      = 1'b1;
        bad_s     = (funct3_s != 3'b000);
      end
      OPC_LUI: begin
        opclass   = OC_LUI;
        imm_sel_s = IMM_U;
        use_imm   = 1'b1;
        alu_op    = ALU_PASSB;
        wr_s      = 1'b1;
      end
      OPC_AUIPC: begin
        opclass   = OC_AUIPC;
        imm_sel_s = IMM_U;
        use_imm   = 1'b1;
        wr_s      = 1'b1;
      end
      OPC_OP: begin
        opclass   = OC_OP;
        rs1_s     = 1'b1;
        rs2_s     = 1'b1;
        wr_s      = 1'b1;
        alu_op    = alu_from_f3(funct3_s, funct7_s[5]);
        bad_s     = !((funct7_s == 7'b0000000) ||
                      ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
      end
      OPC_OPIMM: begin
        opclass   = OC_OPIMM;
        imm_sel_s = IMM_I;
        use_imm   = 1'b1;
        rs1_s     = 1'b1;
        wr_s      = 1'b1;
        alu_op    = alu_from_f3(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
        bad_s     = ((funct3_s == 3'b001) && (funct7_s != 7'b0000000)) ||
                    ((funct3_s == 3'b101) && (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000));
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
  end

  // An illegal instruction reads and writes nothing so it can never stall or mark busy.
  always_comb begin
    illegal = bad_s;
    if (bad_s) begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
    end else begin
      uses_rs1  = rs1_s;
      uses_rs2  = rs2_s;
      writes_rd = wr_s;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: fetch handshake, decoded-control hold register and busy scoreboard.
module id_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  output logic [4:0]      reg_addr1,
  output logic [4:0]      reg_addr2,
  input  logic [XLEN-1:0] reg_read1,
  input  logic [XLEN-1:0] reg_read2,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_alu_op,
  output logic            ex_use_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic [3:0]      ex_opclass,
  output logic [31:0]     ex_pc,
  output logic            ex_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic            flush
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           state_r;
  state_e           state_n_s;
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_n_s;

  logic [4:0]       dec_rs1_s;
  logic [4:0]       dec_rs2_s;
  logic [4:0]       dec_rd_s;
  logic [31:0]      dec_imm_s;
  alu_op_e          dec_alu_op_s;
  opclass_e         dec_opclass_s;
  logic             dec_use_imm_s;
  logic             dec_uses_rs1_s;
  logic             dec_uses_rs2_s;
  logic             dec_writes_rd_s;
  logic             dec_illegal_s;

  logic             hazard_s;
  logic             accept_s;
  logic             dec_reg_write_s;

  logic [4:0]       hold_rs1_r;
  logic [4:0]       hold_rs2_r;
  logic [XLEN-1:0]  ex_imm_r;
  alu_op_e          ex_alu_op_r;
  logic             ex_use_imm_r;
  logic [4:0]       ex_rd_r;
  logic             ex_reg_write_r;
  opclass_e         ex_opclass_r;
  logic [31:0]      ex_pc_r;
  logic             ex_illegal_r;

  rv32_decoder u_dec (
    .instr     (if_instr),
    .rs1       (dec_rs1_s),
    .rs2       (dec_rs2_s),
    .rd        (dec_rd_s),
    .imm       (dec_imm_s),
    .alu_op    (dec_alu_op_s),
    .opclass   (dec_opclass_s),
    .use_imm   (dec_use_imm_s),
    .uses_rs1  (dec_uses_rs1_s),
    .uses_rs2  (dec_uses_rs2_s),
    .writes_rd (dec_writes_rd_s),
    .illegal   (dec_illegal_s)
  );

  // Hazards look at registered busy bits only: the regfile returns pre-write
  // data on its write edge, so a writeback cannot be bypassed into this cycle.
  assign hazard_s = (dec_uses_rs1_s  && busy_r[dec_rs1_s]) ||
                    (dec_uses_rs2_s  && busy_r[dec_rs2_s]) ||
                    (dec_writes_rd_s && busy_r[dec_rd_s]);

  assign ex_valid        = (state_r == ST_FULL);
  assign if_ready        = !rst && !flush && (!ex_valid || ex_ready) && !hazard_s;
  assign accept_s        = if_valid && if_ready;
  assign dec_reg_write_s = dec_writes_rd_s && (dec_rd_s != 5'd0);

  // While stalled, keep re-reading the held operands so read data tracks ex_* every FULL cycle.
  assign reg_addr1 = accept_s ? dec_rs1_s : hold_rs1_r;
  assign reg_addr2 = accept_s ? dec_rs2_s : hold_rs2_r;

  assign ex_rs1_data  = reg_read1;
  assign ex_rs2_data  = reg_read2;
  assign ex_imm       = ex_imm_r;
  assign ex_alu_op    = ex_alu_op_r;
  assign ex_use_imm   = ex_use_imm_r;
  assign ex_rd        = ex_rd_r;
  assign ex_reg_write = ex_reg_write_r;
  assign ex_opclass   = ex_opclass_r;
  assign ex_pc        = ex_pc_r;
  assign ex_illegal   = ex_illegal_r;

  // Occupancy next-state: fill on accept, drain on consume or flush.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_n_s = ST_FULL;
        end else begin
          state_n_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_n_s = ST_EMPTY;
        end else if (accept_s) begin
          state_n_s = ST_FULL;
        end else if (ex_ready) begin
          state_n_s = ST_EMPTY;
        end else begin
          state_n_s = ST_FULL;
        end
      end
      default: begin
        state_n_s = ST_EMPTY;
      end
    endcase
  end

  // Scoreboard update: writeback and flush clear, accept sets (set applied last so it wins).
  always_comb begin
    busy_n_s = busy_r;
    if (wb_en) begin
      busy_n_s[wb_addr] = 1'b0;
    end else begin
      busy_n_s = busy_n_s;
    end
    if (flush && (state_r == ST_FULL) && ex_reg_write_r) begin
      busy_n_s[ex_rd_r] = 1'b0;
    end else begin
      busy_n_s = busy_n_s;
    end
    if (accept_s && dec_reg_write_s) begin
      busy_n_s[dec_rd_s] = 1'b1;
    end else begin
      busy_n_s = busy_n_s;
    end
    busy_n_s[0] = 1'b0;
  end

  // State and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      busy_r  <= {NREGS{1'b0}};
    end else begin
      state_r <= state_n_s;
      busy_r  <= busy_n_s;
    end
  end

  // Hold register: capture decoded control for execute on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rs1_r     <= 5'd0;
      hold_rs2_r     <= 5'd0;
      ex_imm_r       <= {XLEN{1'b0}};
      ex_alu_op_r    <= ALU_ADD;
      ex_use_imm_r   <= 1'b0;
      ex_rd_r        <= 5'd0;
      ex_reg_write_r <= 1'b0;
      ex_opclass_r   <= OC_NONE;
      ex_pc_r        <= 32'd0;
      ex_illegal_r   <= 1'b0;
    end else if (accept_s) begin
      hold_rs1_r     <= dec_rs1_s;
      hold_rs2_r     <= dec_rs2_s;
      ex_imm_r       <= dec_imm_s;
      ex_alu_op_r    <= dec_alu_op_s;
      ex_use_imm_r   <= dec_use_imm_s;
      ex_rd_r        <= dec_rd_s;
      ex_reg_write_r <= dec_reg_write_s;
      ex_opclass_r   <= dec_opclass_s;
      ex_pc_r        <= if_pc;
      ex_illegal_r   <= dec_illegal_s;
    end else begin
      hold_rs1_r     <= hold_rs1_r;
      hold_rs2_r     <= hold_rs2_r;
      ex_imm_r       <= ex_imm_r;
      ex_alu_op_r    <= ex_alu_op_r;
      ex_use_imm_r   <= ex_use_imm_r;
      ex_rd_r        <= ex_rd_r;
      ex_reg_write_r <= ex_reg_write_r;
      ex_opclass_r   <= ex_opclass_r;
      ex_pc_r        <= ex_pc_r;
      ex_illegal_r   <= ex_illegal_r;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage placed directly upstream of the register file.
- Accepts instructions from fetch through a valid/ready handshake, decodes them, and drives the register-file read addresses.
- Registers the decoded control so it arrives at execute in the same cycle as the register file's registered read data.
- A 32-entry busy scoreboard stalls issue on RAW/WAW hazards against writes not yet retired.

Parameters:
- XLEN, 32, data/immediate width
- NREGS, 32, architectural register count (x0 hard-wired zero)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- reg_addr1  out  5  regfile rs1 read address
- reg_addr2  out  5  regfile rs2 read address
- reg_read1  in  32  regfile rs1 data, registered, 1-cycle latency
- reg_read2  in  32  regfile rs2 data, registered, 1-cycle latency
- ex_valid  out  1  decoded instruction valid toward execute
- ex_ready  in  1  execute consumes this cycle
- ex_rs1_data  out  32  = reg_read1, pass-through
- ex_rs2_data  out  32  = reg_read2, pass-through
- ex_imm  out  32  sign-extended immediate
- ex_alu_op  out  4  ALU operation code (package enum)
- ex_use_imm  out  1  ALU operand B selects the immediate
- ex_rd  out  5  destination register
- ex_reg_write  out  1  instruction writes rd (forced 0 when rd = 0)
- ex_opclass  out  4  LOAD/STORE/BRANCH/JAL/JALR/LUI/AUIPC/OP/OPIMM
- ex_pc  out  32  instruction address
- ex_illegal  out  1  unrecognised opcode or funct
- wb_en  in  1  writeback retiring this cycle
- wb_addr  in  5  register being written back
- flush  in  1  discard the held instruction (branch redirect)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - ex_valid=0; busy=0; all held ex_* registers=0.
  - if_ready=0 while rst is high.
- States:
  - EMPTY (ex_valid=0) and FULL (ex_valid=1).
  - accept = if_valid && if_ready.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ex_ready && !accept, or on flush.
  - FULL -> FULL on accept && ex_ready (back-to-back issue).
- if_ready = !rst && !flush && (!ex_valid || ex_ready) && !hazard.
- hazard conditions (each computed from if_instr):
  - uses_rs1 && busy[rs1]
  - uses_rs2 && busy[rs2]
  - writes_rd && busy[rd]
- Hazard check uses the registered busy bits only, with no same-cycle writeback bypass. The regfile returns pre-write data on its write edge, so issue happens at earliest the cycle after the busy bit clears.
- reg_addr1/2:
  - Driven from if_instr[19:15]/[24:20] when accept.
  - Otherwise driven from the held instruction's rs1/rs2, so the regfile keeps re-reading the same registers while FULL stalls.
  - Consequence: reg_read1/2 stay consistent with ex_* every cycle ex_valid=1.
- Latency: instruction accepted at edge N -> ex_valid, decode fields and reg_read data all valid from edge N to edge N+1.
- Decode: I/S/B/U/J immediates per RV32I, sign-extended to XLEN.
  - uses_rs1 = 0 for LUI, AUIPC, JAL.
  - uses_rs2 = 1 only for OP, STORE, BRANCH.
- Illegal instruction:
  - ex_illegal=1 and ex_reg_write=0.
  - No busy bit is set, and the instruction is still issued.
- Scoreboard:
  - Accept with writes_rd and rd!=0 sets busy[rd].
  - wb_en clears busy[wb_addr].
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is always 0.
- flush:
  - ex_valid=0 next cycle; no accept that cycle.
  - Clears the busy bit set by the held instruction if it had ex_reg_write=1.
  - Concurrent wb_en still clears its own bit.
- Reset mid-stall: all state drops; a pending writeback arriving after reset has no effect, since clearing a zero bit is harmless.

Decomposition:
- Package rv32_pkg holds:
  - opcode constants
  - opclass enum
  - alu_op enum
  - immediate-format selectors
- Sub-module rv32_decoder: purely combinational instruction word -> fields, imm, alu_op, uses_rs1/rs2, writes_rd, illegal.
- id_stage keeps the handshake, hold register and scoreboard.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_reg_write=1, ex_use_imm=1, busy[1]=1.
- ADDI x1 followed by ADD x2,x1,x1 (0x00108133) -> if_ready=0 until the cycle after wb_en=1,wb_addr=1; ADD then issues with reg_addr1=reg_addr2=1.
- Hold ex_ready=0 for 3 cycles with an OP in FULL -> reg_addr1/2 and all ex_* outputs stable, if_ready=0, no second accept.
- wb_en=1,wb_addr=3 in the same cycle as accepting an instruction with rd=3 -> busy[3]=1 afterward.
- Opcode 0x7F -> ex_illegal=1, ex_reg_write=0, no busy bit set; flush while FULL with rd=5 -> ex_valid=0, busy[5]=0.
- rst asserted while FULL and stalled -> next cycle ex_valid=0, busy=0, if_ready=1 once rst drops and if_valid is high.
